// File: rtl/mbgd_prod_reduce_accum_if.sv
// Row-in / sum-out handshake bundle for the MBGD product reduce-accumulate block.
// The master drives rows and takes sums; the slave is the reduce-accumulate block.
interface mbgd_prod_reduce_accum_if #(
    parameter int N  = 8,
    parameter int PW = 16,
    parameter int SW = 24
) ();
    logic            prod_valid;
    logic            prod_ready;
    logic [PW*N-1:0] prod_data;
    logic            sum_valid;
    logic            sum_ready;
    logic [SW-1:0]   sum_data;
    logic            sum_ovf;

    modport master (
        output prod_valid, prod_data, sum_ready,
        input  prod_ready, sum_valid, sum_data, sum_ovf
    );

    modport slave (
        input  prod_valid, prod_data, sum_ready,
        output prod_ready, sum_valid, sum_data, sum_ovf
    );
endinterface

// File: rtl/mbgd_prod_reduce_accum.sv
// Reduces N packed unsigned lane products per row through a registered adder tree.
// It accumulates BATCH rows into one sum that is held behind a valid/ready output.
module mbgd_prod_reduce_accum #(
    parameter int N     = 8,
    parameter int PW    = 16,
    parameter int BATCH = 4,
    parameter int SW    = 24
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear_i,
    mbgd_prod_reduce_accum_if.slave bus
);
    localparam int LOG2N = $clog2(N);
    localparam int TW    = PW + LOG2N;
    localparam int CW    = $clog2(BATCH + 1);

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  rowCount_q, rowCount_d;
    logic [SW-1:0]  accum_q, accum_d;
    logic           ovf_q, ovf_d;
    logic [LOG2N:1] lvlValid_q;
    logic [LOG2N:1] lvlLast_q;

    logic [TW-1:0]  lane    [N];
    logic [TW-1:0]  nodeSum [1:N-1];
    logic [TW-1:0]  node_q  [1:N-1];

    logic           accept;
    logic           rowLast;
    logic           finalValid;
    logic           finalLast;
    logic [SW:0]    accumSum;

    assign bus.prod_ready = resetn && (state_q == ST_ACCUM);
    assign accept         = bus.prod_valid && bus.prod_ready && !clear_i;
    assign rowLast        = (rowCount_q == CW'(BATCH - 1));
    assign finalValid     = lvlValid_q[LOG2N];
    assign finalLast      = lvlLast_q[LOG2N];
    assign accumSum       = {1'b0, accum_q} + (SW + 1)'(node_q[1]);

    assign bus.sum_valid  = (state_q == ST_HOLD);
    assign bus.sum_data   = accum_q;
    assign bus.sum_ovf    = ovf_q;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign lane[i] = TW'(bus.prod_data[PW*i +: PW]);
    end

    // Heap-ordered tree: node k sums children 2k and 2k+1, nodes N/2..N-1 sum lane pairs, node 1 is the root.
    for (genvar k = 1; k < N; k++) begin : g_node
        if (k >= N/2) begin : g_leaf
            assign nodeSum[k] = lane[2*k - N] + lane[2*k + 1 - N];
        end else begin : g_inner
            assign nodeSum[k] = node_q[2*k] + node_q[2*k + 1];
        end
    end

    always_ff @(posedge clk) begin
        node_q <= nodeSum;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lvlValid_q <= '0;
            lvlLast_q  <= '0;
        end else if (clear_i) begin
            lvlValid_q <= '0;
            lvlLast_q  <= '0;
        end else begin
            lvlValid_q[1] <= accept;
            lvlLast_q[1]  <= accept && rowLast;
            for (int j = 2; j <= LOG2N; j++) begin
                lvlValid_q[j] <= lvlValid_q[j-1];
                lvlLast_q[j]  <= lvlLast_q[j-1];
            end
        end
    end

    // Rows still in flight keep accumulating while draining; the last-tagged row closes the batch.
    always_comb begin
        state_d    = state_q;
        rowCount_d = rowCount_q;
        accum_d    = accum_q;
        ovf_d      = ovf_q;
        if (finalValid) begin
            accum_d = accumSum[SW-1:0];
            ovf_d   = ovf_q | accumSum[SW];
        end
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (rowLast) begin
                        rowCount_d = '0;
                        state_d    = ST_DRAIN;
                    end else begin
                        rowCount_d = rowCount_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (finalValid && finalLast) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.sum_ready) begin
                    state_d = ST_ACCUM;
                    accum_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
        if (clear_i) begin
            state_d    = ST_ACCUM;
            rowCount_d = '0;
            accum_d    = '0;
            ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_ACCUM;
            rowCount_q <= '0;
            accum_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rowCount_q <= rowCount_d;
            accum_q    <= accum_d;
            ovf_q      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_mbgd_prod_reduce_accum.sv
// Drives a 24-bit and a 20-bit accumulator instance with the same row stream
// and compares both against a batch-level reference model.
module tb_mbgd_prod_reduce_accum;
    localparam int N     = 8;
    localparam int PW    = 16;
    localparam int BATCH = 4;
    localparam int LOG2N = 3;
    localparam int SWA   = 24;
    localparam int SWB   = 20;

    logic            clk = 1'b0;
    logic            resetn;
    logic            clear;
    logic            prodValid;
    logic [PW*N-1:0] prodData;
    logic            sumReady;

    always #5 clk = ~clk;

    mbgd_prod_reduce_accum_if #(.N(N), .PW(PW), .SW(SWA)) busA ();
    mbgd_prod_reduce_accum_if #(.N(N), .PW(PW), .SW(SWB)) busB ();

    assign busA.prod_valid = prodValid;
    assign busA.prod_data  = prodData;
    assign busA.sum_ready  = sumReady;
    assign busB.prod_valid = prodValid;
    assign busB.prod_data  = prodData;
    assign busB.sum_ready  = sumReady;

    mbgd_prod_reduce_accum #(.N(N), .PW(PW), .BATCH(BATCH), .SW(SWA)) dutA (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (clear),
        .bus     (busA)
    );

    mbgd_prod_reduce_accum #(.N(N), .PW(PW), .BATCH(BATCH), .SW(SWB)) dutB (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (clear),
        .bus     (busB)
    );

    typedef enum {MP_COLLECT, MP_WAIT, MP_HOLD} modelPhase_t;

    modelPhase_t mPhase;
    int          mRows;
    int          mWait;
    longint      mTotal;

    int testsRun    = 0;
    int testsFailed = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint laneSum(input logic [PW*N-1:0] d);
        longint s;
        s = 0;
        for (int i = 0; i < N; i++) begin
            s += longint'(d[PW*i +: PW]);
        end
        return s;
    endfunction

    function automatic logic [PW*N-1:0] fillLanes(input logic [PW-1:0] v);
        logic [PW*N-1:0] d;
        for (int i = 0; i < N; i++) begin
            d[PW*i +: PW] = v;
        end
        return d;
    endfunction

    task automatic modelReset();
        mPhase = MP_COLLECT;
        mRows  = 0;
        mWait  = 0;
        mTotal = 0;
    endtask

    // Batch-level model: collect BATCH rows, wait out the tree latency, then hold until taken.
    task automatic modelEdge();
        if (clear) begin
            modelReset();
        end else begin
            case (mPhase)
                MP_COLLECT: begin
                    if (prodValid) begin
                        mTotal += laneSum(prodData);
                        mRows++;
                        if (mRows == BATCH) begin
                            mRows  = 0;
                            mWait  = LOG2N;
                            mPhase = MP_WAIT;
                        end
                    end
                end
                MP_WAIT: begin
                    mWait--;
                    if (mWait == 0) mPhase = MP_HOLD;
                end
                MP_HOLD: begin
                    if (sumReady) begin
                        mTotal = 0;
                        mPhase = MP_COLLECT;
                    end
                end
                default: modelReset();
            endcase
        end
    endtask

    task automatic checkDut();
        checkOutput("A.prod_ready", busA.prod_ready, mPhase == MP_COLLECT);
        checkOutput("B.prod_ready", busB.prod_ready, mPhase == MP_COLLECT);
        checkOutput("A.sum_valid", busA.sum_valid, mPhase == MP_HOLD);
        checkOutput("B.sum_valid", busB.sum_valid, mPhase == MP_HOLD);
        if (mPhase == MP_HOLD) begin
            checkOutput("A.sum_data", busA.sum_data, mTotal % (longint'(1) << SWA));
            checkOutput("B.sum_data", busB.sum_data, mTotal % (longint'(1) << SWB));
            checkOutput("A.sum_ovf", busA.sum_ovf, mTotal >= (longint'(1) << SWA));
            checkOutput("B.sum_ovf", busB.sum_ovf, mTotal >= (longint'(1) << SWB));
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [PW*N-1:0] d, input logic sr, input logic clr);
        prodValid = v;
        prodData  = d;
        sumReady  = sr;
        clear     = clr;
        @(posedge clk);
        modelEdge();
        #1;
        checkDut();
    endtask

    task automatic runRows(input int count, input logic [PW*N-1:0] d);
        for (int i = 0; i < count; i++) applyStimulus(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input int count, input logic sr);
        for (int i = 0; i < count; i++) applyStimulus(1'b0, '0, sr, 1'b0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".A.prod_ready"}, busA.prod_ready, 0);
        checkOutput({tag, ".A.sum_valid"}, busA.sum_valid, 0);
        checkOutput({tag, ".A.sum_data"}, busA.sum_data, 0);
        checkOutput({tag, ".A.sum_ovf"}, busA.sum_ovf, 0);
        checkOutput({tag, ".B.sum_data"}, busB.sum_data, 0);
        checkOutput({tag, ".B.sum_ovf"}, busB.sum_ovf, 0);
    endtask

    task automatic pulseReset(input string tag);
        prodValid = 1'b0;
        sumReady  = 1'b0;
        #2 resetn = 1'b0;
        #1 checkResetOutputs(tag);
        modelReset();
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    initial begin
        logic [PW*N-1:0] ones;
        logic [PW*N-1:0] fulls;
        logic [PW*N-1:0] idx;
        logic [PW*N-1:0] d;
        logic [6:0]      pattern;

        ones  = fillLanes(16'd1);
        fulls = fillLanes(16'hFFFF);
        for (int i = 0; i < N; i++) idx[PW*i +: PW] = PW'(i);
        pattern = 7'b1011001;

        resetn    = 1'b0;
        clear     = 1'b0;
        prodValid = 1'b0;
        prodData  = '0;
        sumReady  = 1'b0;
        modelReset();
        #2 checkResetOutputs("reset");
        @(posedge clk);
        #1 resetn = 1'b1;

        runRows(4, ones);
        idle(3, 1'b0);
        checkOutput("ones.sumA", busA.sum_data, 32);
        checkOutput("ones.ovfA", busA.sum_ovf, 0);
        idle(1, 1'b1);

        runRows(4, fulls);
        idle(3, 1'b0);
        checkOutput("full.sumA", busA.sum_data, 2097120);
        checkOutput("full.ovfA", busA.sum_ovf, 0);
        checkOutput("full.sumB", busB.sum_data, 1048544);
        checkOutput("full.ovfB", busB.sum_ovf, 1);
        idle(1, 1'b1);

        runRows(4, idx);
        idle(3, 1'b0);
        checkOutput("index.sumA", busA.sum_data, 112);
        idle(1, 1'b1);

        runRows(4, ones);
        idle(3, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, fulls, 1'b0, 1'b0);
        checkOutput("bp.sumA", busA.sum_data, 32);
        checkOutput("bp.ready", busA.prod_ready, 0);
        applyStimulus(1'b1, fulls, 1'b1, 1'b0);
        checkOutput("bp.release", busA.prod_ready, 1);

        runRows(3, fulls);
        applyStimulus(1'b1, fulls, 1'b0, 1'b1);
        idle(5, 1'b0);
        checkOutput("clear.valid", busA.sum_valid, 0);
        runRows(4, fulls);
        idle(3, 1'b0);
        checkOutput("clear.sumB", busB.sum_data, 1048544);
        checkOutput("clear.ovfB", busB.sum_ovf, 1);
        idle(1, 1'b1);
        runRows(4, ones);
        idle(3, 1'b0);
        checkOutput("after.sumB", busB.sum_data, 32);
        checkOutput("after.ovfB", busB.sum_ovf, 0);
        idle(1, 1'b1);

        for (int i = 6; i >= 0; i--) applyStimulus(pattern[i], fillLanes(16'd2), 1'b0, 1'b0);
        idle(2, 1'b0);
        checkOutput("gaps.early", busA.sum_valid, 0);
        idle(1, 1'b0);
        checkOutput("gaps.sumA", busA.sum_data, 64);
        idle(1, 1'b1);

        runRows(4, ones);
        idle(1, 1'b0);
        pulseReset("rstDrain");
        runRows(4, fulls);
        idle(4, 1'b0);
        pulseReset("rstHold");
        runRows(4, ones);
        idle(3, 1'b0);
        checkOutput("rst.sumA", busA.sum_data, 32);
        idle(1, 1'b1);

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                d = fulls;
            end else begin
                for (int i = 0; i < N; i++) d[PW*i +: PW] = PW'($urandom_range(0, 65535));
            end
            applyStimulus($urandom_range(0, 9) < 7, d, $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
